// File: rtl/timer_pkg.sv
// Shared definitions for the timer and its capture readout.
// Holds default sizes, the index-width helper and the readout FSM encoding.
package timer_pkg;

    localparam int TIMER_BITWIDTH_DEF = 32;
    localparam int NB_CAPTURES_DEF    = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Smallest width able to index 'value' distinct items.
    function automatic int clog2_f(input int value);
        int result;
        result = 0;
        for (int b = 0; b < 31; b++) begin
            result = ((32'sd1 <<< result) < value) ? result + 1 : result;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after ptr_i,
// wrapping from N-1 to 0. The pointer register lives in the caller.
module rr_arbiter import timer_pkg::*; #(
    parameter  int N     = 4,
    localparam int IDX_W = clog2_f(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             gnt_valid_o,
    output logic [IDX_W-1:0] gnt_idx_o
);

    // Walk distances N..1 so the nearest requester after ptr_i is written last.
    always_comb begin
        int idx;
        idx         = 0;
        gnt_valid_o = 1'b0;
        gnt_idx_o   = '0;
        for (int k = N; k >= 1; k--) begin
            idx         = (int'(ptr_i) + k) % N;
            gnt_valid_o = gnt_valid_o | req_i[idx];
            gnt_idx_o   = req_i[idx] ? IDX_W'(idx) : gnt_idx_o;
        end
    end

endmodule

// File: rtl/capture_readout.sv
// Streams every newly captured timer value as a {channel, value} record over
// a valid/ready port, round-robin across channels, with sticky overrun flags.
module capture_readout import timer_pkg::*; #(
    parameter  int TIMER_BITWIDTH = TIMER_BITWIDTH_DEF,
    parameter  int NB_CAPTURES    = NB_CAPTURES_DEF,
    localparam int CHAN_W         = clog2_f(NB_CAPTURES)
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic [TIMER_BITWIDTH*NB_CAPTURES-1:0] captured_in,
    input  logic [NB_CAPTURES-1:0]              clr_overrun_in,
    output logic                                tx_valid_out,
    input  logic                                tx_ready_in,
    output logic [CHAN_W-1:0]                   tx_chan_out,
    output logic [TIMER_BITWIDTH-1:0]           tx_data_out,
    output logic [NB_CAPTURES-1:0]              pending_out,
    output logic [NB_CAPTURES-1:0]              overrun_out
);

    logic [TIMER_BITWIDTH-1:0] shadow_q [NB_CAPTURES];
    logic [NB_CAPTURES-1:0]    pending_q, pending_d;
    logic [NB_CAPTURES-1:0]    overrun_q, overrun_d;
    logic [NB_CAPTURES-1:0]    change_s, grant_oh_s;
    state_e                    state_q, state_d;
    logic [CHAN_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [CHAN_W-1:0]         tx_chan_q, tx_chan_d;
    logic [TIMER_BITWIDTH-1:0] tx_data_q, tx_data_d;
    logic                      gnt_valid_s;
    logic [CHAN_W-1:0]         gnt_idx_s;
    logic                      load_s;

    // Arbitration only considers changes already registered as pending.
    rr_arbiter #(.N(NB_CAPTURES)) u_arb (
        .req_i       (pending_q),
        .ptr_i       (rr_ptr_q),
        .gnt_valid_o (gnt_valid_s),
        .gnt_idx_o   (gnt_idx_s)
    );

    for (genvar i = 0; i < NB_CAPTURES; i++) begin : g_ch
        assign change_s[i]   = captured_in[i*TIMER_BITWIDTH +: TIMER_BITWIDTH] != shadow_q[i];
        assign grant_oh_s[i] = load_s && (gnt_idx_s == CHAN_W'(i));
        // A change on the channel being granted re-queues it rather than overrunning.
        assign pending_d[i]  = change_s[i] | (pending_q[i] & ~grant_oh_s[i]);
        assign overrun_d[i]  = (change_s[i] & pending_q[i] & ~grant_oh_s[i])
                             | (overrun_q[i] & ~clr_overrun_in[i]);

        // Shadow copy of the last seen capture value for this channel.
        always_ff @(posedge clk_in) begin
            if (rst_in) begin
                shadow_q[i] <= '0;
            end else if (change_s[i]) begin
                shadow_q[i] <= captured_in[i*TIMER_BITWIDTH +: TIMER_BITWIDTH];
            end else begin
                shadow_q[i] <= shadow_q[i];
            end
        end
    end

    // Next-state, grant and record-load decisions.
    always_comb begin
        state_d   = state_q;
        load_s    = 1'b0;
        rr_ptr_d  = rr_ptr_q;
        tx_chan_d = tx_chan_q;
        tx_data_d = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    load_s  = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (tx_ready_in) begin
                    load_s  = gnt_valid_s;
                    state_d = gnt_valid_s ? ST_HOLD : ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (load_s) begin
            rr_ptr_d  = gnt_idx_s;
            tx_chan_d = gnt_idx_s;
            tx_data_d = shadow_q[gnt_idx_s];
        end else begin
            rr_ptr_d  = rr_ptr_q;
        end
    end

    // State, record and per-channel flag registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= CHAN_W'(NB_CAPTURES - 1);
            tx_chan_q <= '0;
            tx_data_q <= '0;
            pending_q <= '0;
            overrun_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            tx_chan_q <= tx_chan_d;
            tx_data_q <= tx_data_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign tx_valid_out = (state_q == ST_HOLD);
    assign tx_chan_out  = tx_chan_q;
    assign tx_data_out  = tx_data_q;
    assign pending_out  = pending_q;
    assign overrun_out  = overrun_q;

endmodule

// File: tb/tb_capture_readout.sv
// Randomized scoreboard bench for capture_readout (8-bit values, 4 channels)
// against a behavioural model of the readout rules.
module tb_capture_readout;

    localparam int W = 8;
    localparam int N = 4;

    typedef struct {
        int ch;
        int data;
    } rec_t;

    logic           clk;
    logic           rst;
    logic [W*N-1:0] captured;
    logic [N-1:0]   clr;
    logic           rdy;
    logic           tx_valid;
    logic [1:0]     tx_chan;
    logic [W-1:0]   tx_data;
    logic [N-1:0]   pending;
    logic [N-1:0]   overrun;

    logic [W-1:0] cap_v [N];
    assign captured = {cap_v[3], cap_v[2], cap_v[1], cap_v[0]};

    capture_readout #(.TIMER_BITWIDTH(W), .NB_CAPTURES(N)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .captured_in    (captured),
        .clr_overrun_in (clr),
        .tx_valid_out   (tx_valid),
        .tx_ready_in    (rdy),
        .tx_chan_out    (tx_chan),
        .tx_data_out    (tx_data),
        .pending_out    (pending),
        .overrun_out    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_recs   = 0;
    bit   mon_en   = 1'b0;
    rec_t exp_q[$];

    // Reference model state
    int       m_shadow [N];
    bit [3:0] m_pend;
    bit [3:0] m_ovr;
    bit       m_hold;
    int       m_ptr;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Apply one clock edge of the readout rules to the model.
    task automatic model_step();
        bit [3:0] chg;
        int g;
        rec_t r;
        if (rst) begin
            if (m_hold && !rdy) void'(exp_q.pop_back());
            for (int i = 0; i < N; i++) m_shadow[i] = 0;
            m_pend = '0; m_ovr = '0; m_hold = 1'b0; m_ptr = N - 1;
            return;
        end
        for (int i = 0; i < N; i++) chg[i] = (int'(cap_v[i]) != m_shadow[i]);
        g = -1;
        if (!m_hold || rdy) begin
            m_hold = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (g < 0 && m_pend[c]) g = c;
            end
            if (g >= 0) begin
                r.ch = g; r.data = m_shadow[g];
                exp_q.push_back(r);
                m_hold = 1'b1;
                m_ptr  = g;
            end
        end
        for (int i = 0; i < N; i++) begin
            m_ovr[i]  = (m_ovr[i] && !clr[i]) || (chg[i] && m_pend[i] && i != g);
            m_pend[i] = chg[i] || (m_pend[i] && i != g);
            if (chg[i]) m_shadow[i] = int'(cap_v[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        clr = '0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Monitor: compare registered outputs with the model, and records with the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("tx_valid", int'(tx_valid), int'(m_hold));
            chk("pending", int'(pending), int'(m_pend));
            chk("overrun", int'(overrun), int'(m_ovr));
            if (tx_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_record", 1, 0);
                end else begin
                    chk("rec_chan", int'(tx_chan), exp_q[0].ch);
                    chk("rec_data", int'(tx_data), exp_q[0].data);
                    if (rdy) begin
                        void'(exp_q.pop_front());
                        n_recs++;
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1; rdy = 1'b0; clr = '0;
        for (int i = 0; i < N; i++) cap_v[i] = '0;
        ticks(2);
        chk("reset_chan", int'(tx_chan), 0);
        chk("reset_data", int'(tx_data), 0);
        mon_en = 1'b1;
        rst = 1'b0;
        ticks(2);

        // 1: single change on ch2
        rdy = 1'b1;
        cap_v[2] = 8'h5A;
        ticks(6);

        // 2: three channels change together, back-to-back beats
        cap_v[0] = 8'h01; cap_v[1] = 8'h02; cap_v[3] = 8'h03;
        ticks(8);

        // 3: overrun on ch1 while ch0 is held
        rdy = 1'b0;
        cap_v[0] = 8'h44;
        ticks(3);
        cap_v[1] = 8'h10; tick();
        cap_v[1] = 8'h11; ticks(2);
        chk("overrun1_set", int'(overrun[1]), 1);
        rdy = 1'b1;
        ticks(5);
        clr[1] = 1'b1; tick();
        ticks(1);
        chk("overrun1_clr", int'(overrun[1]), 0);

        // 4: held record stays stable while all channels toggle
        rdy = 1'b0;
        cap_v[0] = 8'h70;
        ticks(3);
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < N; i++) cap_v[i] = 8'(8'h80 + t * 4 + i);
            tick();
        end
        ticks(2);
        rdy = 1'b1;
        ticks(8);

        // 5: reset while a record is held and ch1/ch3 pending
        rdy = 1'b0;
        cap_v[0] = 8'h21; ticks(3);
        cap_v[1] = 8'h22; cap_v[3] = 8'h23; ticks(2);
        chk("pre_reset_pending", int'(pending), 4'b1010);
        for (int i = 0; i < N; i++) cap_v[i] = '0;
        rst = 1'b1; tick();
        rst = 1'b0;
        chk("post_reset_chan", int'(tx_chan), 0);
        chk("post_reset_data", int'(tx_data), 0);
        rdy = 1'b1;
        ticks(6);

        // 6: repeated identical value on ch3
        for (int t = 0; t < 6; t++) begin
            cap_v[3] = 8'h33;
            tick();
        end
        ticks(4);

        // Random phase
        for (int t = 0; t < 600; t++) begin
            rdy = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 9) == 0) cap_v[i] = 8'($urandom_range(0, 255));
                clr[i] = ($urandom_range(0, 15) == 0);
            end
            tick();
        end

        // Drain
        rdy = 1'b1;
        clr = '0;
        ticks(20);
        chk("queue_drained", exp_q.size(), 0);
        chk("records_seen_nonzero", int'(n_recs > 20), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
